// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU consumer stage: opcode encodings,
// FSM state encoding and default opcode width.
package uart_alu_pkg;

    localparam int OP_W_DEF = 6;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_e;

endpackage

// File: rtl/uart_alu_interface_alu.sv
// Combinational ALU: result = a op b, truncated to N bits; unknown opcodes give 0.
module alu
    import uart_alu_pkg::*;
#(
    parameter int N    = 8,
    parameter int OP_W = OP_W_DEF
) (
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    input  logic [OP_W-1:0] op,
    output logic [N-1:0]    result
);

    localparam int SH_W = $clog2(N) + 1;

    // Amounts of N and above saturate naturally: zero fill for SRL, sign fill for SRA.
    logic [SH_W-1:0] shamt;
    assign shamt = b[SH_W-1:0];

    always_comb begin
        result = '0;
        case (op)
            OP_W'(OP_ADD): result = a + b;
            OP_W'(OP_SUB): result = a - b;
            OP_W'(OP_AND): result = a & b;
            OP_W'(OP_OR):  result = a | b;
            OP_W'(OP_XOR): result = a ^ b;
            OP_W'(OP_NOR): result = ~(a | b);
            OP_W'(OP_SRA): result = $signed(a) >>> shamt;
            OP_W'(OP_SRL): result = a >> shamt;
            default:       result = '0;
        endcase
    end

endmodule

// File: rtl/uart_alu_interface.sv
// Collects A, B, opcode bytes from uart_rx, runs one ALU op and hands the result to uart_tx.
// Optional inter-byte timeout enabled by defining UART_ALU_TIMEOUT_EN.
module uart_alu_interface
    import uart_alu_pkg::*;
#(
    parameter int N              = 8,
    parameter int OP_W           = OP_W_DEF,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] rx_data,
    input  logic         rx_valid,
    input  logic         tx_done,
    output logic [N-1:0] tx_data,
    output logic         tx_start,
    output logic         busy,
    output logic [N-1:0] result_out,
    output logic         overrun
);

    state_e          state_q;
    logic [N-1:0]    op_a_q;
    logic [N-1:0]    op_b_q;
    logic [OP_W-1:0] opcode_q;
    logic [N-1:0]    tx_data_q;
    logic [N-1:0]    result_q;
    logic            tx_start_q;
    logic            busy_q;
    logic            overrun_q;
    logic [N-1:0]    alu_result_d;
    logic            tmo_hit_d;

    alu #(.N(N), .OP_W(OP_W)) u_alu (
        .a      (op_a_q),
        .b      (op_b_q),
        .op     (opcode_q),
        .result (alu_result_d)
    );

`ifdef UART_ALU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             in_frame_d;

    assign in_frame_d = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
    // An arriving byte on the last cycle beats the timeout.
    assign tmo_hit_d  = in_frame_d && !rx_valid && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || rx_valid || !in_frame_d || tmo_hit_d) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    // Constant false for any legal TIMEOUT_CYCLES: frames wait indefinitely.
    assign tmo_hit_d = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_WAIT_A;
            op_a_q     <= '0;
            op_b_q     <= '0;
            opcode_q   <= '0;
            tx_data_q  <= '0;
            result_q   <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            overrun_q  <= 1'b0;
            case (state_q)
                ST_WAIT_A: begin
                    if (rx_valid) begin
                        op_a_q  <= rx_data;
                        state_q <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (rx_valid) begin
                        op_b_q  <= rx_data;
                        state_q <= ST_WAIT_OP;
                    end else if (tmo_hit_d) begin
                        op_a_q  <= '0;
                        state_q <= ST_WAIT_A;
                    end
                end
                ST_WAIT_OP: begin
                    if (rx_valid) begin
                        opcode_q <= rx_data[OP_W-1:0];
                        busy_q   <= 1'b1;
                        state_q  <= ST_EXEC;
                    end else if (tmo_hit_d) begin
                        op_a_q  <= '0;
                        op_b_q  <= '0;
                        state_q <= ST_WAIT_A;
                    end
                end
                ST_EXEC: begin
                    tx_data_q  <= alu_result_d;
                    result_q   <= alu_result_d;
                    tx_start_q <= 1'b1;
                    overrun_q  <= rx_valid;
                    state_q    <= ST_SEND;
                end
                ST_SEND: begin
                    overrun_q <= rx_valid;
                    state_q   <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (tx_done) begin
                        busy_q  <= 1'b0;
                        // A byte landing with tx_done starts the next frame.
                        if (rx_valid) begin
                            op_a_q  <= rx_data;
                            state_q <= ST_WAIT_B;
                        end else begin
                            state_q <= ST_WAIT_A;
                        end
                    end else begin
                        overrun_q <= rx_valid;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_WAIT_A;
                end
            endcase
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign busy       = busy_q;
    assign result_out = result_q;
    assign overrun    = overrun_q;

endmodule
